// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 keypad scanner.
// Imported by the scanner top and its debounce FSM.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } key_state_e;

  typedef enum logic [1:0] {
    FrNone,
    FrSingle,
    FrMulti
  } frame_class_e;

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debounce FSM: accepts a press after DEBOUNCE_FRAMES identical SINGLE frames
// and a release after DEBOUNCE_FRAMES frames without the held key.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             i_frame_end,
  input  frame_class_e     i_frame_class,
  input  logic [KEY_W-1:0] i_frame_code,
  output logic             o_key_valid,
  output logic [KEY_W-1:0] o_key_code,
  output logic             o_key_held,
  output logic [KEY_W-1:0] o_led
);

  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

  key_state_e       r_state;
  logic [3:0]       r_cnt;
  logic [KEY_W-1:0] r_cand;
  logic [KEY_W-1:0] r_code;
  logic [KEY_W-1:0] r_led;
  logic             r_valid;
  logic             r_held;

  logic [3:0] w_cnt_inc;
  logic       w_release;
  logic       w_accept;

  assign w_cnt_inc = r_cnt + 4'd1;

  // A frame without the held key (empty, or a different single key) counts toward release.
  always_comb begin
    w_release = (i_frame_class == FrNone) ||
                ((i_frame_class == FrSingle) && (i_frame_code != r_code));
    w_accept  = 1'b0;
    if (i_frame_end && (i_frame_class == FrSingle)) begin
      if (r_state == StIdle) begin
        w_accept = (DF == 4'd1);
      end else if ((r_state == StPressWait) && (i_frame_code == r_cand)) begin
        w_accept = (w_cnt_inc == DF);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_code  <= '0;
      r_led   <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_led   <= r_code;
        r_code  <= i_frame_code;
        r_cand  <= i_frame_code;
        r_held  <= 1'b1;
        r_cnt   <= '0;
        r_state <= StHeld;
      end else if (i_frame_end) begin
        unique case (r_state)
          StIdle: begin
            if (i_frame_class == FrSingle) begin
              r_cand  <= i_frame_code;
              r_cnt   <= 4'd1;
              r_state <= StPressWait;
            end
          end
          StPressWait: begin
            if ((i_frame_class == FrSingle) && (i_frame_code == r_cand)) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_cnt   <= '0;
              r_state <= StIdle;
            end
          end
          StHeld: begin
            if (w_release) begin
              if (DF == 4'd1) begin
                r_held  <= 1'b0;
                r_cnt   <= '0;
                r_state <= StIdle;
              end else begin
                r_cnt   <= 4'd1;
                r_state <= StReleaseWait;
              end
            end
          end
          StReleaseWait: begin
            if (w_release) begin
              if (w_cnt_inc == DF) begin
                r_held  <= 1'b0;
                r_cnt   <= '0;
                r_state <= StIdle;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_cnt   <= '0;
              r_state <= StHeld;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_key_valid = r_valid;
  assign o_key_code  = r_code;
  assign o_key_held  = r_held;
  assign o_led       = r_led;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates one active-low column, samples synchronized rows at
// the end of each dwell and classifies every 4-column frame for the debounce FSM.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic             clock,
  input  logic             reset_,
  output logic [COLS-1:0]  col_,
  input  logic [ROWS-1:0]  row_,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             key_held,
  output logic [KEY_W-1:0] led
);

  localparam int unsigned  DW         = $clog2(SCAN_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

  logic [ROWS-1:0]  r_row_s1;
  logic [ROWS-1:0]  r_row_s2;
  logic [DW-1:0]    r_dwell;
  logic [1:0]       r_col;
  logic [1:0]       r_hits;  // 0, 1, or 2 meaning "two or more"
  logic [KEY_W-1:0] r_hit_code;
  logic             r_frame_end;
  frame_class_e     r_frame_class;
  logic [KEY_W-1:0] r_frame_code;

  logic             w_sample;
  logic [2:0]       w_col_cnt;
  logic [1:0]       w_col_row;
  logic [2:0]       w_hits_sum;
  logic [1:0]       w_hits_next;
  logic [KEY_W-1:0] w_code_next;
  frame_class_e     w_class;

  assign w_sample = (r_dwell == DWELL_LAST);

  always_comb begin
    w_col_cnt = '0;
    w_col_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!r_row_s2[r]) begin
        w_col_cnt = w_col_cnt + 3'd1;
        w_col_row = 2'(r);
      end
    end
    w_hits_sum  = {1'b0, r_hits} + w_col_cnt;
    w_hits_next = (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];
    w_code_next = ((r_hits == 2'd0) && (w_col_cnt == 3'd1)) ? {w_col_row, r_col} : r_hit_code;
    unique case (w_hits_next)
      2'd0:    w_class = FrNone;
      2'd1:    w_class = FrSingle;
      default: w_class = FrMulti;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_row_s1      <= '1;
      r_row_s2      <= '1;
      r_dwell       <= '0;
      r_col         <= '0;
      r_hits        <= '0;
      r_hit_code    <= '0;
      r_frame_end   <= 1'b0;
      r_frame_class <= FrNone;
      r_frame_code  <= '0;
    end else begin
      r_row_s1    <= row_;
      r_row_s2    <= r_row_s1;
      r_frame_end <= 1'b0;
      if (w_sample) begin
        r_dwell <= '0;
        r_col   <= r_col + 2'd1;
        if (r_col == 2'd3) begin
          r_frame_end   <= 1'b1;
          r_frame_class <= w_class;
          r_frame_code  <= w_code_next;
          r_hits        <= '0;
          r_hit_code    <= '0;
        end else begin
          r_hits     <= w_hits_next;
          r_hit_code <= w_code_next;
        end
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  assign col_ = ~({{(COLS-1){1'b0}}, 1'b1} << r_col);

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clock        (clock),
    .reset_       (reset_),
    .i_frame_end  (r_frame_end),
    .i_frame_class(r_frame_class),
    .i_frame_code (r_frame_code),
    .o_key_valid  (key_valid),
    .o_key_code   (key_code),
    .o_key_held   (key_held),
    .o_led        (led)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a combinational keypad model (SCAN_CYCLES=4,
// DEBOUNCE_FRAMES=3, so one frame is 16 clocks).
module tb_keypad_scan;

  localparam int unsigned SC    = 4;
  localparam int unsigned DF    = 3;
  localparam int          FRAME = 16;

  logic       clock;
  logic       reset_;
  logic [3:0] col_;
  logic [3:0] row_;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [3:0] led;

  logic [15:0] keys;  // bit r*4+c set while key (r,c) is pressed
  int          total;
  int          bad;
  int          pulses;
  int          held_drops;
  logic        mon_en;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic [3:0]  exp_led;
    logic        exp_held;
  } step_t;

  step_t steps[12];

  keypad_scan #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .clock    (clock),
    .reset_   (reset_),
    .col_     (col_),
    .row_     (row_),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held),
    .led      (led)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always_comb begin
    row_ = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!col_[c] && keys[r*4+c]) row_[r] = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (key_valid === 1'b1) pulses++;
    if (mon_en && key_held !== 1'b1) held_drops++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts just after a negedge that precedes a frame boundary; ends the same way.
  task automatic apply_step(input int idx, input step_t s);
    int p0;
    keys = s.keys;
    p0   = pulses;
    repeat (s.frames * FRAME) @(negedge clock);
    #1;
    check($sformatf("step%0d pulses", idx), 32'(pulses - p0), 32'(s.exp_pulses));
    check($sformatf("step%0d key_code", idx), 32'(key_code), 32'(s.exp_code));
    check($sformatf("step%0d led", idx), 32'(led), 32'(s.exp_led));
    check($sformatf("step%0d key_held", idx), 32'(key_held), 32'(s.exp_held));
  endtask

  initial begin
    logic [3:0] exp_col;
    total      = 0;
    bad        = 0;
    pulses     = 0;
    held_drops = 0;
    mon_en     = 1'b0;
    keys       = '0;
    reset_     = 1'b0;

    // Scenario 2: hold (1,2), release
    steps[0]  = '{16'h0040, 6, 1, 4'h6, 4'h0, 1'b1};
    steps[1]  = '{16'h0000, 4, 0, 4'h6, 4'h0, 1'b0};
    // Scenario 3: bounce on/off/on-on/off
    steps[2]  = '{16'h0040, 1, 0, 4'h6, 4'h0, 1'b0};
    steps[3]  = '{16'h0000, 1, 0, 4'h6, 4'h0, 1'b0};
    steps[4]  = '{16'h0040, 2, 0, 4'h6, 4'h0, 1'b0};
    steps[5]  = '{16'h0000, 2, 0, 4'h6, 4'h0, 1'b0};
    // Scenario 4: hold (3,1), release
    steps[6]  = '{16'h2000, 4, 1, 4'hD, 4'h6, 1'b1};
    steps[7]  = '{16'h0000, 4, 0, 4'hD, 4'h6, 1'b0};
    // Scenario 5: (0,1)+(0,2) together -> ghosting, ignored
    steps[8]  = '{16'h0006, 5, 0, 4'hD, 4'h6, 1'b0};
    steps[9]  = '{16'h0000, 1, 0, 4'hD, 4'h6, 1'b0};
    // Scenario 6: hold (2,0), short release, re-press
    steps[10] = '{16'h0100, 4, 1, 4'h8, 4'hD, 1'b1};
    steps[11] = '{16'h0000, 2, 0, 4'h8, 4'hD, 1'b1};

    repeat (3) @(negedge clock);
    reset_ = 1'b1;
    #1;
    check("reset col_", 32'(col_), 32'hE);
    check("reset key_valid", 32'(key_valid), 32'h0);
    check("reset key_code", 32'(key_code), 32'h0);
    check("reset key_held", 32'(key_held), 32'h0);
    check("reset led", 32'(led), 32'h0);

    // Scenario 1: idle 10 frames, column rotates every SC clocks
    for (int k = 0; k < 10 * FRAME; k++) begin
      @(negedge clock);
      exp_col = 4'hF;
      exp_col[((k + 1) / SC) % 4] = 1'b0;
      if (k % SC == SC - 1) check($sformatf("idle col_ k=%0d", k), 32'(col_), 32'(exp_col));
    end
    #1;
    check("idle pulses", 32'(pulses), 32'h0);
    check("idle key_code", 32'(key_code), 32'h0);
    check("idle key_held", 32'(key_held), 32'h0);

    // Reset mid-rotation must force column 0 at once
    repeat (5) @(negedge clock);
    check("pre-reset col_ moved", 32'(col_), 32'hD);
    reset_ = 1'b0;
    #1;
    check("mid reset col_", 32'(col_), 32'hE);
    @(negedge clock);
    reset_ = 1'b1;
    #1;

    for (int i = 0; i < 11; i++) apply_step(i, steps[i]);

    mon_en = 1'b1;
    apply_step(11, steps[11]);
    apply_step(12, '{16'h0100, 3, 0, 4'h8, 4'hD, 1'b1});
    mon_en = 1'b0;
    check("s6 key_held never dropped", 32'(held_drops), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
